// File: rtl/uart_bus_pkg.sv
// Shared definitions for the 6502-style UART bus initiator.
package uart_bus_pkg;

  typedef logic [1:0] op_t;

  // Command op codes
  localparam op_t OP_RD  = 2'b00;
  localparam op_t OP_WR  = 2'b01;
  localparam op_t OP_PUT = 2'b10;
  localparam op_t OP_GET = 2'b11;

  // Peripheral register map
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;

  // Status register bits
  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_RX_EMPTY = 1;

  // FSM state encoding
  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitEdge = 3'd1;
  localparam logic [2:0] StPoll     = 3'd2;
  localparam logic [2:0] StXfer     = 3'd3;
  localparam logic [2:0] StResp     = 3'd4;

  // Status bit that blocks the transfer: tx_full for PUT, rx_empty for GET.
  function automatic logic [2:0] poll_bit(op_t op);
    return (op == OP_PUT) ? 3'(ST_TX_FULL) : 3'(ST_RX_EMPTY);
  endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// Command/response handshake plus peripheral bus pins of the UART bus initiator.
interface uart_bus_master_if;
  import uart_bus_pkg::*;

  // Peripheral bus
  logic       phi2;
  logic       ncs;
  logic       rwb;
  logic [1:0] addr;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] data_in;

  // Command / response
  logic       cmd_valid;
  logic       cmd_ready;
  op_t        cmd_op;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output phi2, ncs, rwb, addr, data_out, data_oe, cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  data_in, cmd_valid, cmd_op, cmd_addr, cmd_wdata
  );

  modport slave (
    input  phi2, ncs, rwb, addr, data_out, data_oe, cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output data_in, cmd_valid, cmd_op, cmd_addr, cmd_wdata
  );

endinterface

// File: rtl/phi2_gen.sv
// Free-running phi2 generator: PHI2_HALF fabric clocks per half-period, low phase after reset.
module phi2_gen #(
  parameter int unsigned PHI2_HALF = 8
) (
  input  logic clk,
  input  logic reset,
  output logic phi2,
  output logic fall,
  output logic sample
);

  localparam int unsigned CntW = $clog2(PHI2_HALF);
  localparam logic [CntW-1:0] CntLast = CntW'(PHI2_HALF - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            phi2_q, phi2_d;
  logic            wrap;

  // Phase counter wraps at PHI2_HALF-1 and toggles phi2.
  always_comb begin
    wrap   = (cnt_q == CntLast);
    cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
    phi2_d = wrap ? ~phi2_q : phi2_q;
  end

  // Counter and phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      phi2_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      phi2_q <= phi2_d;
    end
  end

  // The last high-phase clock both samples read data and launches the falling edge.
  assign phi2   = phi2_q;
  assign fall   = wrap & phi2_q;
  assign sample = wrap & phi2_q;

endmodule

// File: rtl/uart_bus_master.sv
// Turns single-word commands into phi2 bus cycles; PUT/GET poll status before moving data.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned PHI2_HALF = 8,
  parameter int unsigned MAX_POLLS = 255
) (
  input logic               clk,
  input logic               reset,
  uart_bus_master_if.master bus_io
);

  logic phi2, fall, sample;

  phi2_gen #(
    .PHI2_HALF(PHI2_HALF)
  ) u_phi2_gen (
    .clk   (clk),
    .reset (reset),
    .phi2  (phi2),
    .fall  (fall),
    .sample(sample)
  );

  logic [2:0] state_q, state_d;
  op_t        op_q, op_d;
  logic [1:0] caddr_q, caddr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] poll_cnt_q, poll_cnt_d;
  logic       ncs_q, ncs_d;
  logic       rwb_q, rwb_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;

  logic       xfer_rd;
  logic [1:0] xfer_addr;
  logic [8:0] poll_inc;
  logic       poll_busy;
  logic       start_xfer, finish;

  // Decode the data transfer cycle and the polled status bit from the latched command.
  always_comb begin
    xfer_rd = (op_q == OP_RD) || (op_q == OP_GET);
    case (op_q)
      OP_PUT:  xfer_addr = REG_TXDATA;
      OP_GET:  xfer_addr = REG_RXDATA;
      default: xfer_addr = caddr_q;
    endcase
    poll_inc  = {1'b0, poll_cnt_q} + 9'd1;
    poll_busy = bus_io.data_in[poll_bit(op_q)];
  end

  // Next-state logic: bus pins only change on the fall strobe that ends a cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    caddr_d     = caddr_q;
    wdata_d     = wdata_q;
    poll_cnt_d  = poll_cnt_q;
    ncs_d       = ncs_q;
    rwb_d       = rwb_q;
    addr_d      = addr_q;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    start_xfer  = 1'b0;
    finish      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus_io.cmd_valid && cmd_ready_q) begin
          op_d        = bus_io.cmd_op;
          caddr_d     = bus_io.cmd_addr;
          wdata_d     = bus_io.cmd_wdata;
          poll_cnt_d  = '0;
          cmd_ready_d = 1'b0;
          state_d     = StWaitEdge;
        end
      end
      StWaitEdge: begin
        if (fall) begin
          if (op_q == OP_PUT || op_q == OP_GET) begin
            state_d   = StPoll;
            ncs_d     = 1'b0;
            rwb_d     = 1'b1;
            addr_d    = REG_STATUS;
            data_oe_d = 1'b0;
          end else begin
            start_xfer = 1'b1;
          end
        end
      end
      StPoll: begin
        // sample coincides with the fall strobe, so the next cycle is set up on this edge
        if (sample) begin
          if (!poll_busy) begin
            start_xfer = 1'b1;
          end else begin
            poll_cnt_d = poll_inc[7:0];
            if (poll_inc == 9'(MAX_POLLS)) begin
              finish      = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = 8'h00;
            end
          end
        end
      end
      StXfer: begin
        if (sample) begin
          finish      = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = rwb_q ? bus_io.data_in : 8'h00;
        end
      end
      StResp: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (start_xfer) begin
      state_d   = StXfer;
      ncs_d     = 1'b0;
      rwb_d     = xfer_rd;
      addr_d    = xfer_addr;
      data_oe_d = !xfer_rd;
      if (!xfer_rd) data_out_d = wdata_q;
    end

    // Bus returns to idle in the same update that raises rsp_valid.
    if (finish) begin
      state_d     = StResp;
      rsp_valid_d = 1'b1;
      ncs_d       = 1'b1;
      rwb_d       = 1'b1;
      data_oe_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= OP_RD;
      caddr_q     <= '0;
      wdata_q     <= '0;
      poll_cnt_q  <= '0;
      ncs_q       <= 1'b1;
      rwb_q       <= 1'b1;
      addr_q      <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      caddr_q     <= caddr_d;
      wdata_q     <= wdata_d;
      poll_cnt_q  <= poll_cnt_d;
      ncs_q       <= ncs_d;
      rwb_q       <= rwb_d;
      addr_q      <= addr_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus_io.phi2      = phi2;
  assign bus_io.ncs       = ncs_q;
  assign bus_io.rwb       = rwb_q;
  assign bus_io.addr      = addr_q;
  assign bus_io.data_out  = data_out_q;
  assign bus_io.data_oe   = data_oe_q;
  assign bus_io.cmd_ready = cmd_ready_q;
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_rdata = rsp_rdata_q;
  assign bus_io.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_uart_bus_master.sv
// Self-checking bench for uart_bus_master with a small UART peripheral model.
module tb_uart_bus_master;
  import uart_bus_pkg::*;

  localparam int unsigned PHI2_HALF = 8;
  localparam int unsigned MAX_POLLS = 4;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_bus_master_if bus();

  uart_bus_master #(
    .PHI2_HALF(PHI2_HALF),
    .MAX_POLLS(MAX_POLLS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  rsp_t exp_q[$];

  int clk_cnt = 0;
  always @(posedge clk) clk_cnt <= clk_cnt + 1;

  // Peripheral model: status = {rx_empty, tx_full}; tx_full holds for the first N status reads.
  int   status_reads = 0;
  int   status_base = 0;
  int   tx_full_polls = 0;
  logic rx_empty_stuck = 1'b0;
  logic [7:0] status_val;
  always_comb status_val = {6'b0, rx_empty_stuck, ((status_reads - status_base) <= tx_full_polls)};
  assign bus.data_in = (bus.addr == REG_STATUS) ? status_val :
                       (bus.addr == REG_RXDATA) ? 8'hA5 : 8'h3C;

  // Bus monitor: logs each active cycle and counts protocol violations.
  logic       prev_phi2 = 1'b0;
  int         cyc_count = 0;
  int         bus_bad = 0;
  int         rsp_count = 0;
  logic       cur_rwb = 1'b1;
  logic [1:0] cur_addr = 2'd0;
  logic [7:0] cur_wdata = 8'd0;
  logic       log_rwb[256];
  logic [1:0] log_addr[256];
  logic [7:0] log_wdata[256];
  int         log_clk[256];

  always @(negedge clk) begin
    prev_phi2 <= bus.phi2;
    if (bus.rsp_valid) rsp_count <= rsp_count + 1;
    if (!reset) begin
      if (!bus.ncs && prev_phi2 && !bus.phi2) begin
        log_rwb[cyc_count[7:0]]   <= bus.rwb;
        log_addr[cyc_count[7:0]]  <= bus.addr;
        log_wdata[cyc_count[7:0]] <= bus.data_out;
        log_clk[cyc_count[7:0]]   <= clk_cnt;
        cyc_count <= cyc_count + 1;
        cur_rwb   <= bus.rwb;
        cur_addr  <= bus.addr;
        cur_wdata <= bus.data_out;
        if (bus.rwb && bus.addr == REG_STATUS) status_reads <= status_reads + 1;
        if (bus.rwb ? (bus.data_oe !== 1'b0) : (bus.data_oe !== 1'b1)) bus_bad <= bus_bad + 1;
      end else if (!bus.ncs) begin
        if (bus.rwb !== cur_rwb || bus.addr !== cur_addr ||
            (bus.rwb ? (bus.data_oe !== 1'b0)
                     : (bus.data_oe !== 1'b1 || bus.data_out !== cur_wdata)))
          bus_bad <= bus_bad + 1;
      end else if (bus.data_oe !== 1'b0) begin
        bus_bad <= bus_bad + 1;
      end
    end
  end

  // Issue one command and wait (bounded) for its response; returns what was observed.
  task automatic run_cmd(input op_t op, input logic [1:0] a, input logic [7:0] wd,
                         input int hold_extra, output logic seen, output logic [7:0] rd,
                         output logic er, output int acc_clk, output int rsp_clk,
                         output logic rdy_acc, output logic idle_rsp, output logic rdy_rsp);
    int n;
    seen = 1'b0; rd = 8'h00; er = 1'b0; rsp_clk = 0; idle_rsp = 1'b0; rdy_rsp = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
    bus.cmd_op = op; bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
    @(negedge clk);
    acc_clk = clk_cnt;
    rdy_acc = bus.cmd_ready;
    // a different request held while busy must be ignored
    bus.cmd_op = OP_RD; bus.cmd_addr = REG_RXDATA;
    repeat (hold_extra) @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 1000) begin @(negedge clk); n++; end
    if (bus.rsp_valid) begin
      seen = 1'b1;
      rd = bus.rsp_rdata;
      er = bus.rsp_err;
      rsp_clk = clk_cnt;
      idle_rsp = bus.ncs && bus.rwb && !bus.data_oe;
      @(negedge clk);
      rdy_rsp = bus.cmd_ready && !bus.rsp_valid;
    end
  endtask

  // Wait (bounded) until phi2 reaches a new level, returning the clock count.
  task automatic wait_phi2(input logic level, output int t, output logic ok);
    int n = 0;
    while (bus.phi2 === level && n < 100) begin @(negedge clk); n++; end
    while (bus.phi2 !== level && n < 100) begin @(negedge clk); n++; end
    ok = (bus.phi2 === level);
    t = clk_cnt;
  endtask

  task automatic test_reset();
    int t_r1, t_f, t_r2, b;
    logic ok1, ok2, ok3;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.phi2, bus.ncs, bus.rwb, bus.addr, bus.data_out, bus.data_oe} !== {3'b011, 2'd0, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_bus: got phi2/ncs/rwb/addr/dout/oe=%b/%b/%b/%h/%h/%b want 0/1/1/0/00/0",
               bus.phi2, bus.ncs, bus.rwb, bus.addr, bus.data_out, bus.data_oe);
    end
    tests_run++;
    if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err} !== {2'b10, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_cmd: got ready/valid/rdata/err=%b/%b/%h/%b want 1/0/00/0",
               bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    @(negedge clk);
    reset = 1'b0;
    b = cyc_count;
    wait_phi2(1'b1, t_r1, ok1);
    wait_phi2(1'b0, t_f, ok2);
    wait_phi2(1'b1, t_r2, ok3);
    tests_run++;
    if (!(ok1 && ok2 && ok3) || t_r2 - t_r1 != 16) begin
      tests_failed++;
      $display("FAIL phi2_period: got %0d clocks (edges seen %b%b%b) want 16", t_r2 - t_r1, ok1, ok2, ok3);
    end
    tests_run++;
    if (t_f - t_r1 != 8) begin
      tests_failed++;
      $display("FAIL phi2_high: got %0d clocks want 8", t_f - t_r1);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (cyc_count != b || bus.ncs !== 1'b1 || bus.cmd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_bus: got cycles=%0d ncs=%b ready=%b want 0/1/1", cyc_count - b, bus.ncs, bus.cmd_ready);
    end
  endtask

  task automatic test_write();
    logic seen, er, ra, ia, rr;
    logic [7:0] rd;
    int ac, rc, b, bad0, rc0;
    rsp_t e;
    b = cyc_count; bad0 = bus_bad; rc0 = rsp_count;
    exp_q.push_back({8'h00, 1'b0});
    run_cmd(OP_WR, REG_TXDATA, 8'h41, 4, seen, rd, er, ac, rc, ra, ia, rr);
    repeat (40) @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (seen !== 1'b1) begin tests_failed++; $display("FAIL wr_rsp_seen: got %b want 1", seen); end
    tests_run++;
    if ({rd, er} !== e) begin
      tests_failed++;
      $display("FAIL wr_rsp: got rdata=%h err=%b want rdata=%h err=%b", rd, er, e.rdata, e.err);
    end
    tests_run++;
    if (ra !== 1'b0) begin tests_failed++; $display("FAIL wr_ready_drop: got %b want 0", ra); end
    tests_run++;
    if (cyc_count - b != 1) begin tests_failed++; $display("FAIL wr_cycles: got %0d want 1", cyc_count - b); end
    tests_run++;
    if ({log_rwb[b[7:0]], log_addr[b[7:0]], log_wdata[b[7:0]]} !== {1'b0, REG_TXDATA, 8'h41}) begin
      tests_failed++;
      $display("FAIL wr_cycle: got rwb/addr/data=%b/%h/%h want 0/2/41",
               log_rwb[b[7:0]], log_addr[b[7:0]], log_wdata[b[7:0]]);
    end
    tests_run++;
    if (bus_bad != bad0) begin tests_failed++; $display("FAIL wr_bus_stable: got %0d violations want 0", bus_bad - bad0); end
    tests_run++;
    if (ia !== 1'b1) begin tests_failed++; $display("FAIL wr_idle_at_rsp: got %b want 1", ia); end
    tests_run++;
    if (rr !== 1'b1) begin tests_failed++; $display("FAIL wr_ready_return: got %b want 1", rr); end
    tests_run++;
    if (rsp_count - rc0 != 1) begin tests_failed++; $display("FAIL wr_ignore_busy: got %0d responses want 1", rsp_count - rc0); end
  endtask

  task automatic test_read();
    logic seen, er, ra, ia, rr;
    logic [7:0] rd;
    int ac, rc, b, bad0;
    rsp_t e;
    rx_empty_stuck = 1'b1; tx_full_polls = 0; status_base = status_reads;
    b = cyc_count; bad0 = bus_bad;
    exp_q.push_back({8'h02, 1'b0});
    run_cmd(OP_RD, REG_STATUS, 8'hFF, 0, seen, rd, er, ac, rc, ra, ia, rr);
    e = exp_q.pop_front();
    tests_run++;
    if (seen !== 1'b1 || {rd, er} !== e) begin
      tests_failed++;
      $display("FAIL rd_status: got seen=%b rdata=%h err=%b want 1/%h/%b", seen, rd, er, e.rdata, e.err);
    end
    tests_run++;
    if (rc - ac < 17 || rc - ac > 32) begin tests_failed++; $display("FAIL rd_latency: got %0d want 17..32", rc - ac); end
    tests_run++;
    if (cyc_count - b != 1 || {log_rwb[b[7:0]], log_addr[b[7:0]]} !== {1'b1, REG_STATUS}) begin
      tests_failed++;
      $display("FAIL rd_cycle: got cycles=%0d rwb/addr=%b/%h want 1 cycle 1/0",
               cyc_count - b, log_rwb[b[7:0]], log_addr[b[7:0]]);
    end
    tests_run++;
    if (bus_bad != bad0) begin tests_failed++; $display("FAIL rd_bus_stable: got %0d violations want 0", bus_bad - bad0); end
    // back-to-back read of the rx data register
    exp_q.push_back({8'hA5, 1'b0});
    run_cmd(OP_RD, REG_RXDATA, 8'h00, 0, seen, rd, er, ac, rc, ra, ia, rr);
    e = exp_q.pop_front();
    tests_run++;
    if (seen !== 1'b1 || {rd, er} !== e) begin
      tests_failed++;
      $display("FAIL rd_rxdata: got seen=%b rdata=%h err=%b want 1/%h/%b", seen, rd, er, e.rdata, e.err);
    end
  endtask

  task automatic test_put();
    logic seen, er, ra, ia, rr;
    logic [7:0] rd;
    int ac, rc, b, bad0, polls;
    rsp_t e;
    rx_empty_stuck = 1'b0; tx_full_polls = 3; status_base = status_reads;
    b = cyc_count; bad0 = bus_bad;
    exp_q.push_back({8'h00, 1'b0});
    run_cmd(OP_PUT, 2'd3, 8'h55, 0, seen, rd, er, ac, rc, ra, ia, rr);
    e = exp_q.pop_front();
    tests_run++;
    if (seen !== 1'b1 || {rd, er} !== e) begin
      tests_failed++;
      $display("FAIL put_rsp: got seen=%b rdata=%h err=%b want 1/%h/%b", seen, rd, er, e.rdata, e.err);
    end
    polls = 0;
    for (int i = 0; i < 4; i++) begin
      if ({log_rwb[8'(b + i)], log_addr[8'(b + i)]} === {1'b1, REG_STATUS}) polls++;
    end
    tests_run++;
    if (cyc_count - b != 5 || polls != 4) begin
      tests_failed++;
      $display("FAIL put_polls: got cycles=%0d status_reads=%0d want 5/4", cyc_count - b, polls);
    end
    tests_run++;
    if ({log_rwb[8'(b + 4)], log_addr[8'(b + 4)], log_wdata[8'(b + 4)]} !== {1'b0, REG_TXDATA, 8'h55}) begin
      tests_failed++;
      $display("FAIL put_write: got rwb/addr/data=%b/%h/%h want 0/2/55",
               log_rwb[8'(b + 4)], log_addr[8'(b + 4)], log_wdata[8'(b + 4)]);
    end
    tests_run++;
    if (rc - log_clk[b[7:0]] != 80) begin
      tests_failed++;
      $display("FAIL put_latency: got %0d clocks want 80", rc - log_clk[b[7:0]]);
    end
    tests_run++;
    if (bus_bad != bad0) begin tests_failed++; $display("FAIL put_bus_stable: got %0d violations want 0", bus_bad - bad0); end
  endtask

  task automatic test_get_timeout();
    logic seen, er, ra, ia, rr;
    logic [7:0] rd;
    int ac, rc, b, polls;
    rsp_t e;
    rx_empty_stuck = 1'b1; tx_full_polls = 0; status_base = status_reads;
    b = cyc_count;
    exp_q.push_back({8'h00, 1'b1});
    run_cmd(OP_GET, 2'd0, 8'h00, 0, seen, rd, er, ac, rc, ra, ia, rr);
    e = exp_q.pop_front();
    tests_run++;
    if (seen !== 1'b1 || {rd, er} !== e) begin
      tests_failed++;
      $display("FAIL get_err_rsp: got seen=%b rdata=%h err=%b want 1/%h/%b", seen, rd, er, e.rdata, e.err);
    end
    polls = 0;
    for (int i = 0; i < 4; i++) begin
      if ({log_rwb[8'(b + i)], log_addr[8'(b + i)]} === {1'b1, REG_STATUS}) polls++;
    end
    tests_run++;
    if (cyc_count - b != 4 || polls != 4) begin
      tests_failed++;
      $display("FAIL get_polls: got cycles=%0d status_reads=%0d want 4/4", cyc_count - b, polls);
    end
    tests_run++;
    if (rc - log_clk[b[7:0]] != 64) begin
      tests_failed++;
      $display("FAIL get_latency: got %0d clocks want 64", rc - log_clk[b[7:0]]);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if ({bus.rsp_rdata, bus.rsp_err} !== {8'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL get_rsp_hold: got rdata=%h err=%b want 00/1", bus.rsp_rdata, bus.rsp_err);
    end
  endtask

  task automatic test_reset_mid_write();
    logic seen, er, ra, ia, rr;
    logic [7:0] rd;
    int ac, rc, rc0, n;
    rsp_t e;
    rc0 = rsp_count;
    n = 0;
    while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
    bus.cmd_op = OP_WR; bus.cmd_addr = 2'd3; bus.cmd_wdata = 8'h99; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.ncs === 1'b0 && bus.phi2 === 1'b1) && n < 100) begin @(negedge clk); n++; end
    tests_run++;
    if (!(bus.ncs === 1'b0 && bus.phi2 === 1'b1)) begin
      tests_failed++;
      $display("FAIL mid_wr_start: got ncs=%b phi2=%b want 0/1", bus.ncs, bus.phi2);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.ncs, bus.data_oe, bus.phi2, bus.cmd_ready} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL mid_wr_reset: got ncs/oe/phi2/ready=%b/%b/%b/%b want 1/0/0/1",
               bus.ncs, bus.data_oe, bus.phi2, bus.cmd_ready);
    end
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (rsp_count != rc0) begin tests_failed++; $display("FAIL mid_wr_no_rsp: got %0d responses want 0", rsp_count - rc0); end
    rx_empty_stuck = 1'b1; tx_full_polls = 0; status_base = status_reads;
    exp_q.push_back({8'h02, 1'b0});
    run_cmd(OP_RD, REG_STATUS, 8'h00, 0, seen, rd, er, ac, rc, ra, ia, rr);
    e = exp_q.pop_front();
    tests_run++;
    if (seen !== 1'b1 || {rd, er} !== e) begin
      tests_failed++;
      $display("FAIL rd_after_reset: got seen=%b rdata=%h err=%b want 1/%h/%b", seen, rd, er, e.rdata, e.err);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = OP_RD;
    bus.cmd_addr = 2'd0;
    bus.cmd_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_put();
    test_get_timeout();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
